// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module     : dmem_arbiter_if
//  Description: Bundle of the two requester ports (m0 = core LSU, m1 = DMA/
//               debug loader) and the data_memory port of dmem_arbiter.
//               slave  : arbiter view (takes requests, drives grants/memory)
//               master : environment view (requesters plus data_memory)
//  Signals    : mX_req/we/addr/wdata   requester -> arbiter
//               mX_gnt/rvalid/rdata    arbiter -> requester
//               mem_A/WD/MemWrite      arbiter -> data_memory
//               mem_RD                 data_memory -> arbiter
//  Revision   : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] mem_A;
    logic [DW-1:0] mem_WD;
    logic          mem_MemWrite;
    logic [DW-1:0] mem_RD;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_A, mem_WD, mem_MemWrite,
        input  mem_RD
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_A, mem_WD, mem_MemWrite,
        output mem_RD
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : dmem_arbiter
//  Description: Round-robin, burst-limited arbiter sharing a single-port
//               data_memory between m0 (core LSU) and m1 (DMA/debug loader).
//               The memory reads combinationally and writes on the clock
//               edge, so the grant and memory mux are combinational; read
//               data is captured and returned one cycle after the grant.
//  Ports      : clk    clock, rising edge
//               rst_n  asynchronous active-low reset
//               bus    dmem_arbiter_if.slave (requesters + memory port)
//  Parameters : AW address width, DW data width,
//               MAX_BURST consecutive grants to one owner while the other
//               requester waits (>=1)
//  Revision   : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    localparam int              c_cw      = $clog2(MAX_BURST + 1);
    localparam logic [c_cw-1:0] c_max_cnt = c_cw'(MAX_BURST);
    localparam logic [c_cw-1:0] c_one     = c_cw'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } own_t;

    own_t            r_own;
    own_t            w_own_nxt;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_nxt;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_burst_left;

    logic            r_m0_rvalid;
    logic            r_m1_rvalid;
    logic [DW-1:0]   r_m0_rdata;
    logic [DW-1:0]   r_m1_rdata;

    // The owner may keep the memory only while its burst budget lasts; the
    // budget matters only when the other requester is actually waiting.
    assign w_burst_left = (r_cnt < c_max_cnt);

    always_comb begin
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_own_nxt = ST_IDLE;
        w_cnt_nxt = '0;

        case (r_own)
            ST_OWN0: begin
                if (bus.m0_req && (!bus.m1_req || w_burst_left)) begin
                    w_gnt0 = 1'b1;
                end else if (bus.m1_req) begin
                    w_gnt1 = 1'b1;
                end
            end
            ST_OWN1: begin
                if (bus.m1_req && (!bus.m0_req || w_burst_left)) begin
                    w_gnt1 = 1'b1;
                end else if (bus.m0_req) begin
                    w_gnt0 = 1'b1;
                end
            end
            default: begin
                if (bus.m0_req) begin
                    w_gnt0 = 1'b1;
                end else if (bus.m1_req) begin
                    w_gnt1 = 1'b1;
                end
            end
        endcase

        // Grants are suppressed while reset is held so that no write can
        // commit into the memory during reset.
        if (!rst_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end

        if (w_gnt0) begin
            w_own_nxt = ST_OWN0;
            if (r_own == ST_OWN0) begin
                w_cnt_nxt = w_burst_left ? r_cnt + c_one : r_cnt;
            end else begin
                w_cnt_nxt = c_one;
            end
        end else if (w_gnt1) begin
            w_own_nxt = ST_OWN1;
            if (r_own == ST_OWN1) begin
                w_cnt_nxt = w_burst_left ? r_cnt + c_one : r_cnt;
            end else begin
                w_cnt_nxt = c_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_own <= ST_IDLE;
            r_cnt <= '0;
        end else begin
            r_own <= w_own_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Memory port mux: idle bus drives zeros.
    assign bus.mem_A        = w_gnt0 ? bus.m0_addr  : (w_gnt1 ? bus.m1_addr  : '0);
    assign bus.mem_WD       = w_gnt0 ? bus.m0_wdata : (w_gnt1 ? bus.m1_wdata : '0);
    assign bus.mem_MemWrite = (w_gnt0 & bus.m0_we) | (w_gnt1 & bus.m1_we);

    // Read return: capture the combinational memory output at the end of the
    // read grant cycle; rvalid is a single-cycle pulse, rdata holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_rvalid <= w_gnt0 & ~bus.m0_we;
            r_m1_rvalid <= w_gnt1 & ~bus.m1_we;
            if (w_gnt0 && !bus.m0_we) begin
                r_m0_rdata <= bus.mem_RD;
            end
            if (w_gnt1 && !bus.m1_we) begin
                r_m1_rdata <= bus.mem_RD;
            end
        end
    end

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.m0_rvalid = r_m0_rvalid;
    assign bus.m1_rvalid = r_m1_rvalid;
    assign bus.m0_rdata  = r_m0_rdata;
    assign bus.m1_rdata  = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : tb_dmem_arbiter
//  Description: Self-checking bench for dmem_arbiter. A behavioural model
//               (owner/streak bookkeeping plus a shadow memory) predicts
//               every grant, memory-port value and read return; directed
//               scenarios are followed by randomized traffic with resets.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // data_memory stand-in: combinational read, write on the clock edge
    logic [DW-1:0] tmem [256] = '{default: '0};
    assign bus.mem_RD = tmem[bus.mem_A[9:2]];
    always @(posedge clk) begin
        if (bus.mem_MemWrite) tmem[bus.mem_A[9:2]] <= bus.mem_WD;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_chk++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp_v, $time);
    endtask

    // ------------------------------------------------------------------
    // Stimulus state and reference model
    // ------------------------------------------------------------------
    bit            rstv;
    bit            req [2];
    bit            we  [2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wd  [2];

    int            m_owner;              // -1 none, else port number
    int            m_streak;             // consecutive grants to m_owner
    logic [DW-1:0] shadow [256] = '{default: '0};
    bit            exp_rv [2];
    logic [DW-1:0] exp_rd [2];
    int            last_g;               // predicted winner of last cycle

    function automatic int winner();
        int o, x;
        if (!rstv) return -1;
        if (m_owner < 0) return req[0] ? 0 : (req[1] ? 1 : -1);
        o = m_owner;
        x = 1 - o;
        if (req[o] && (!req[x] || m_streak < MB)) return o;
        if (req[x]) return x;
        return -1;
    endfunction

    // One clock cycle: drive at the falling edge, check just after, then
    // advance the model to what the next rising edge must produce.
    task automatic tick();
        int g;
        @(negedge clk);
        rst_n        = rstv;
        bus.m0_req   = req[0]; bus.m0_we = we[0]; bus.m0_addr = addr[0]; bus.m0_wdata = wd[0];
        bus.m1_req   = req[1]; bus.m1_we = we[1]; bus.m1_addr = addr[1]; bus.m1_wdata = wd[1];
        #1;
        if (!rstv) begin
            m_owner  = -1;
            m_streak = 0;
            for (int p = 0; p < 2; p++) begin
                exp_rv[p] = 1'b0;
                exp_rd[p] = '0;
            end
        end
        check("m0_rvalid", bus.m0_rvalid, exp_rv[0]);
        check("m1_rvalid", bus.m1_rvalid, exp_rv[1]);
        check("m0_rdata",  bus.m0_rdata,  exp_rd[0]);
        check("m1_rdata",  bus.m1_rdata,  exp_rd[1]);

        g = winner();
        check("m0_gnt", bus.m0_gnt, g == 0);
        check("m1_gnt", bus.m1_gnt, g == 1);
        check("mem_A",  bus.mem_A,  (g >= 0) ? addr[g] : '0);
        check("mem_WD", bus.mem_WD, (g >= 0) ? wd[g]   : '0);
        check("mem_we", bus.mem_MemWrite, (g >= 0) ? we[g] : 1'b0);
        last_g = g;

        for (int p = 0; p < 2; p++) begin
            exp_rv[p] = (g == p) && !we[p];
            if (exp_rv[p]) exp_rd[p] = shadow[addr[p][9:2]];
        end
        if (g >= 0 && we[g]) shadow[addr[g][9:2]] = wd[g];

        if (g < 0) begin
            m_owner  = -1;
            m_streak = 0;
        end else if (g == m_owner) begin
            m_streak = (m_streak < MB) ? m_streak + 1 : MB;
        end else begin
            m_owner  = g;
            m_streak = 1;
        end
    endtask

    task automatic idle_all();
        req[0] = 1'b0;
        req[1] = 1'b0;
    endtask

    task automatic set_port(input int p, input bit r, input bit w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p] = r; we[p] = w; addr[p] = a; wd[p] = d;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    initial begin
        int g0_seen;
        m_owner  = -1;
        m_streak = 0;
        last_g   = -1;
        for (int p = 0; p < 2; p++) begin
            exp_rv[p] = 1'b0;
            exp_rd[p] = '0;
            set_port(p, 1'b0, 1'b0, '0, '0);
        end

        // 1: reset holds off a pending write; release grants m0
        rstv = 1'b0;
        set_port(0, 1'b1, 1'b1, 32'h10, 32'h5a5a_0001);
        tick();
        tick();
        check("t1_gnt_in_rst", bus.m0_gnt, 1'b0);
        check("t1_we_in_rst",  bus.mem_MemWrite, 1'b0);
        rstv = 1'b1;
        tick();
        check("t1_gnt_after", bus.m0_gnt, 1'b1);

        // 2: write by m0 then read-after-write by m1 next cycle
        set_port(0, 1'b1, 1'b1, 32'h0, 32'habcd_ef12);
        tick();
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b1, 1'b0, 32'h0, '0);
        tick();
        check("t2_m1_gnt", bus.m1_gnt, 1'b1);
        idle_all();
        tick();
        check("t2_rvalid", bus.m1_rvalid, 1'b1);
        check("t2_rdata",  bus.m1_rdata,  32'habcd_ef12);

        // 3: both read continuously from IDLE -> alternating bursts of 4
        idle_all();
        tick();
        for (int i = 0; i < 16; i++) begin
            set_port(0, 1'b1, 1'b0, 32'($urandom_range(0, 255)) << 2, '0);
            set_port(1, 1'b1, 1'b0, 32'($urandom_range(0, 255)) << 2, '0);
            tick();
            check("t3_pattern", bus.m0_gnt, (i % 8) < 4);
        end

        // 4: fill words, then m1 streams 10 reads without a stall
        idle_all();
        for (int i = 0; i < 10; i++) begin
            set_port(0, 1'b1, 1'b1, 32'(i * 4), 32'hc0de_0000 + 32'(i));
            tick();
        end
        idle_all();
        tick();
        for (int i = 0; i < 10; i++) begin
            set_port(1, 1'b1, 1'b0, 32'(i * 4), '0);
            tick();
            check("t4_stream_gnt", bus.m1_gnt, 1'b1);
            if (i > 0) check("t4_order", bus.m1_rdata, 32'hc0de_0000 + 32'(i - 1));
        end
        idle_all();
        tick();
        check("t4_last", bus.m1_rdata, 32'hc0de_0009);

        // 5: reset in the middle of an m1 burst
        set_port(1, 1'b1, 1'b0, 32'h4, '0);
        tick();
        tick();
        rstv = 1'b1;
        rstv = 1'b0;
        set_port(0, 1'b1, 1'b1, 32'h40, 32'hdead_beef);
        tick();
        check("t5_rvalid_clr", bus.m1_rvalid, 1'b0);
        check("t5_no_write",   bus.mem_MemWrite, 1'b0);
        rstv = 1'b1;
        set_port(0, 1'b1, 1'b0, 32'h40, '0);
        tick();
        check("t5_first_m0", bus.m0_gnt, 1'b1);

        // 6: m0 gives up while m1 owns; owner returns to IDLE afterwards
        idle_all();
        tick();
        set_port(1, 1'b1, 1'b0, 32'h8, '0);
        tick();
        g0_seen = 0;
        set_port(0, 1'b1, 1'b0, 32'hc, '0);
        for (int i = 0; i < 2; i++) begin
            tick();
            g0_seen += int'(bus.m0_gnt);
        end
        req[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            g0_seen += int'(bus.m0_gnt);
        end
        check("t6_m0_never", 64'(g0_seen), 64'd0);
        check("t6_m1_cont",  bus.m1_gnt, 1'b1);
        idle_all();
        tick();
        req[0] = 1'b1;
        req[1] = 1'b1;
        tick();
        check("t6_idle_prio", bus.m0_gnt, 1'b1);

        // Randomized traffic: requests held until granted, occasional
        // drops and single-cycle resets.
        idle_all();
        for (int n = 0; n < 600; n++) begin
            rstv = ($urandom_range(0, 99) != 0);
            for (int p = 0; p < 2; p++) begin
                if (req[p] && last_g == p && $urandom_range(0, 1) == 0) req[p] = 1'b0;
                if (req[p] && $urandom_range(0, 19) == 0) req[p] = 1'b0;
                if (!req[p] || last_g == p) begin
                    if ($urandom_range(0, 2) != 0) begin
                        set_port(p, 1'b1, 1'($urandom_range(0, 1)),
                                 32'($urandom) & 32'h3ff, 32'($urandom));
                    end else begin
                        req[p] = 1'b0;
                    end
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
